// File: rtl/tile_draw_datapath.sv
// Pixel datapath for the four-tile memory game: tile/flash colour loading, 8x8 pixel walk,
// LFSR tile picker and an optional 16-entry sequence store enabled by `define SEQ_STORE_EN.
module tile_draw_datapath (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ld_tile,
  input  logic       ld_flash,
  input  logic [1:0] tile_num,
  input  logic       randomEnable,
  input  logic       counterEnable,
  input  logic       writeEnable,
  input  logic       seq_clear,
  input  logic [3:0] seq_rd_addr,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [1:0] seq_rd_tile,
  output logic [4:0] seq_len,
  output logic       seq_full
);

  localparam logic [2:0] FLASH_COLOUR = 3'b111;

  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] cur_tile_q, cur_tile_d;
  logic       flash_pending_q, flash_pending_d;
  logic [2:0] colour_reg_q, colour_reg_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       append;

  function automatic logic [2:0] base_colour(input logic [1:0] t);
    case (t)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [7:0] origin_x(input logic [1:0] t);
    return t[0] ? 8'd82 : 8'd70;
  endfunction

  function automatic logic [6:0] origin_y(input logic [1:0] t);
    return t[1] ? 7'd62 : 7'd50;
  endfunction

  // Tile/colour/counter load logic; ld_tile has priority over ld_flash.
  always_comb begin
    lfsr_d          = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cur_tile_d      = cur_tile_q;
    flash_pending_d = flash_pending_q;
    colour_reg_d    = colour_reg_q;
    cnt_d           = cnt_q;
    append          = 1'b0;
    if (ld_tile) begin
      flash_pending_d = 1'b0;
      cnt_d           = 6'd0;
      if (randomEnable) begin
        cur_tile_d = lfsr_q[1:0];
        append     = 1'b1;
      end else if (!flash_pending_q) begin
        cur_tile_d = tile_num;
      end
      colour_reg_d = base_colour(cur_tile_d);
    end else if (ld_flash) begin
      flash_pending_d = 1'b1;
      cnt_d           = 6'd0;
      colour_reg_d    = FLASH_COLOUR;
    end else if (counterEnable) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  // Coordinates and colour are captured together so colour never leads position.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = writeEnable;
    if (writeEnable) begin
      x_d      = origin_x(cur_tile_q) + {5'd0, cnt_q[2:0]};
      y_d      = origin_y(cur_tile_q) + {4'd0, cnt_q[5:3]};
      colour_d = colour_reg_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr_q          <= 8'hA5;
      cur_tile_q      <= 2'd0;
      flash_pending_q <= 1'b0;
      colour_reg_q    <= 3'd0;
      cnt_q           <= 6'd0;
      x_q             <= 8'd0;
      y_q             <= 7'd0;
      colour_q        <= 3'd0;
      plot_q          <= 1'b0;
    end else begin
      lfsr_q          <= lfsr_d;
      cur_tile_q      <= cur_tile_d;
      flash_pending_q <= flash_pending_d;
      colour_reg_q    <= colour_reg_d;
      cnt_q           <= cnt_d;
      x_q             <= x_d;
      y_q             <= y_d;
      colour_q        <= colour_d;
      plot_q          <= plot_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

`ifdef SEQ_STORE_EN
  logic [1:0] seq_mem_q [16];
  logic [1:0] seq_mem_d [16];
  logic [4:0] seq_len_q, seq_len_d;
  logic [1:0] seq_rd_tile_q, seq_rd_tile_d;
  logic       seq_we;

  // A clear in the same cycle as an append drops the append.
  always_comb begin
    seq_we    = append && !seq_clear && (seq_len_q != 5'd16);
    seq_mem_d = seq_mem_q;
    seq_len_d = seq_len_q;
    if (seq_clear) begin
      seq_len_d = 5'd0;
    end else if (seq_we) begin
      seq_mem_d[seq_len_q[3:0]] = lfsr_q[1:0];
      seq_len_d                 = seq_len_q + 5'd1;
    end
    seq_rd_tile_d = ({1'b0, seq_rd_addr} < seq_len_q) ? seq_mem_q[seq_rd_addr] : 2'b00;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) seq_mem_q[i] <= 2'b00;
      seq_len_q     <= 5'd0;
      seq_rd_tile_q <= 2'b00;
    end else begin
      seq_mem_q     <= seq_mem_d;
      seq_len_q     <= seq_len_d;
      seq_rd_tile_q <= seq_rd_tile_d;
    end
  end

  assign seq_len     = seq_len_q;
  assign seq_full    = (seq_len_q == 5'd16);
  assign seq_rd_tile = seq_rd_tile_q;
`else
  logic unused_seq;
  assign unused_seq  = ^{seq_clear, seq_rd_addr, append};
  assign seq_len     = 5'd0;
  assign seq_full    = 1'b0;
  assign seq_rd_tile = 2'b00;
`endif

endmodule

// File: tb/tb_tile_draw_datapath.sv
// Directed bench for tile_draw_datapath: boot draw, flash/restore, sequence store,
// simultaneous events and asynchronous reset mid-draw.
module tb_tile_draw_datapath;

`ifdef SEQ_STORE_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ld_tile = 1'b0;
  logic       ld_flash = 1'b0;
  logic [1:0] tile_num = 2'd0;
  logic       randomEnable = 1'b0;
  logic       counterEnable = 1'b0;
  logic       writeEnable = 1'b0;
  logic       seq_clear = 1'b0;
  logic [3:0] seq_rd_addr = 4'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [1:0] seq_rd_tile;
  logic [4:0] seq_len;
  logic       seq_full;

  int checks = 0;
  int failures = 0;

  logic [7:0] lfsr_m;
  logic [1:0] exp_q[$];

  always #5 clock = ~clock;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) lfsr_m <= 8'hA5;
    else         lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  tile_draw_datapath dut (
    .clock(clock), .resetn(resetn), .ld_tile(ld_tile), .ld_flash(ld_flash),
    .tile_num(tile_num), .randomEnable(randomEnable), .counterEnable(counterEnable),
    .writeEnable(writeEnable), .seq_clear(seq_clear), .seq_rd_addr(seq_rd_addr),
    .x(x), .y(y), .colour(colour), .plot(plot), .seq_rd_tile(seq_rd_tile),
    .seq_len(seq_len), .seq_full(seq_full)
  );

  function automatic logic [7:0] ox(input logic [1:0] t);
    return t[0] ? 8'd82 : 8'd70;
  endfunction

  function automatic logic [6:0] oy(input logic [1:0] t);
    return t[1] ? 7'd62 : 7'd50;
  endfunction

  function automatic logic [2:0] base_c(input logic [1:0] t);
    case (t)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  task automatic apply_reset();
    resetn = 1'b0;
    ld_tile = 1'b0; ld_flash = 1'b0; randomEnable = 1'b0; counterEnable = 1'b0;
    writeEnable = 1'b0; seq_clear = 1'b0; seq_rd_addr = 4'd0; tile_num = 2'd0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic load_tile(input bit rnd, input logic [1:0] tn, output logic [1:0] t);
    t = rnd ? lfsr_m[1:0] : tn;
    ld_tile = 1'b1; randomEnable = rnd; tile_num = tn;
    @(posedge clock); #1;
    ld_tile = 1'b0; randomEnable = 1'b0;
    if (rnd && exp_q.size() < 16) exp_q.push_back(t);
  endtask

  task automatic pulse_flash();
    ld_flash = 1'b1;
    @(posedge clock); #1;
    ld_flash = 1'b0;
  endtask

  task automatic pulse_clear();
    seq_clear = 1'b1;
    @(posedge clock); #1;
    seq_clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic draw_pass(input logic [1:0] t, input logic [2:0] c, input string name);
    logic [7:0] ex;
    logic [6:0] ey;
    writeEnable = 1'b1; counterEnable = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(posedge clock); #1;
      ex = ox(t) + 8'(k % 8);
      ey = oy(t) + 7'(k / 8);
      checks++;
      if (plot !== 1'b1 || x !== ex || y !== ey || colour !== c) begin
        failures++;
        $display("FAIL %s pix%0d: got plot=%b x=%0d y=%0d col=%b, want plot=1 x=%0d y=%0d col=%b",
                 name, k, plot, x, y, colour, ex, ey, c);
      end
    end
    writeEnable = 1'b0; counterEnable = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (plot !== 1'b0 || x !== ex || y !== ey || colour !== c) begin
      failures++;
      $display("FAIL %s idle: got plot=%b x=%0d y=%0d col=%b, want plot=0 x=%0d y=%0d col=%b",
               name, plot, x, y, colour, ex, ey, c);
    end
  endtask

  task automatic write_one(input logic [7:0] ex, input logic [6:0] ey, input logic [2:0] ec,
                           input string name);
    writeEnable = 1'b1;
    @(posedge clock); #1;
    writeEnable = 1'b0;
    checks++;
    if (plot !== 1'b1 || x !== ex || y !== ey || colour !== ec) begin
      failures++;
      $display("FAIL %s: got plot=%b x=%0d y=%0d col=%b, want plot=1 x=%0d y=%0d col=%b",
               name, plot, x, y, colour, ex, ey, ec);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || plot !== 1'b0) begin
      failures++;
      $display("FAIL reset_pixel: got x=%0d y=%0d col=%b plot=%b, want all 0", x, y, colour, plot);
    end
    checks++;
    if (seq_len !== 5'd0 || seq_full !== 1'b0 || seq_rd_tile !== 2'd0) begin
      failures++;
      $display("FAIL reset_seq: got len=%0d full=%b rd=%0d, want 0 0 0", seq_len, seq_full, seq_rd_tile);
    end
  endtask

  task automatic test_boot_draw();
    logic [1:0] t;
    load_tile(1'b0, 2'd2, t);
    draw_pass(2'd2, 3'b001, "boot_tile2");
  endtask

  task automatic test_flash_restore();
    logic [1:0] t;
    logic [1:0] unused_t;
    load_tile(1'b1, 2'd0, t);
    draw_pass(t, base_c(t), "rand_base");
    pulse_flash();
    draw_pass(t, 3'b111, "flash");
    load_tile(1'b0, 2'd0, unused_t);
    draw_pass(t, base_c(t), "restore");
  endtask

  task automatic test_seq_fill();
    logic [1:0] t;
    logic [4:0] exp_len;
    logic [1:0] exp_tile;
    pulse_clear();
    checks++;
    if (seq_len !== 5'd0) begin
      failures++;
      $display("FAIL seq_clear_start: got len=%0d, want 0", seq_len);
    end
    for (int i = 0; i < 17; i++) begin
      load_tile(1'b1, 2'd0, t);
      exp_len = SEQ_ON ? ((i + 1 > 16) ? 5'd16 : 5'(i + 1)) : 5'd0;
      checks++;
      if (seq_len !== exp_len) begin
        failures++;
        $display("FAIL seq_len_load%0d: got %0d, want %0d", i, seq_len, exp_len);
      end
    end
    checks++;
    if (seq_full !== SEQ_ON) begin
      failures++;
      $display("FAIL seq_full: got %b, want %b", seq_full, SEQ_ON);
    end
    for (int a = 0; a < 16; a++) begin
      seq_rd_addr = 4'(a);
      @(posedge clock); #1;
      exp_tile = SEQ_ON ? exp_q[a] : 2'd0;
      checks++;
      if (seq_rd_tile !== exp_tile) begin
        failures++;
        $display("FAIL seq_read%0d: got %0d, want %0d", a, seq_rd_tile, exp_tile);
      end
    end
    pulse_clear();
    checks++;
    if (seq_len !== 5'd0 || seq_full !== 1'b0) begin
      failures++;
      $display("FAIL seq_clear_end: got len=%0d full=%b, want 0 0", seq_len, seq_full);
    end
    for (int a = 0; a < 16; a++) begin
      seq_rd_addr = 4'(a);
      @(posedge clock); #1;
      checks++;
      if (seq_rd_tile !== 2'd0) begin
        failures++;
        $display("FAIL seq_read_cleared%0d: got %0d, want 0", a, seq_rd_tile);
      end
    end
    seq_rd_addr = 4'd0;
  endtask

  task automatic test_simultaneous();
    logic [1:0] t;
    logic [4:0] exp_len;
    // ld_tile and ld_flash together: tile load wins
    ld_tile = 1'b1; ld_flash = 1'b1; tile_num = 2'd1;
    @(posedge clock); #1;
    ld_tile = 1'b0; ld_flash = 1'b0;
    write_one(8'd82, 7'd50, 3'b010, "ld_both");
    // no flash pending, so a plain ld_tile takes tile_num
    load_tile(1'b0, 2'd3, t);
    write_one(8'd82, 7'd62, 3'b110, "after_both_no_pending");
    // counterEnable with a load leaves the counter at 0
    counterEnable = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    ld_tile = 1'b1; tile_num = 2'd2;
    @(posedge clock); #1;
    ld_tile = 1'b0; counterEnable = 1'b0;
    write_one(8'd70, 7'd62, 3'b001, "cnt_vs_load");
    // seq_clear wins over a coincident random append
    load_tile(1'b1, 2'd0, t);
    exp_len = SEQ_ON ? 5'd1 : 5'd0;
    checks++;
    if (seq_len !== exp_len) begin
      failures++;
      $display("FAIL seq_pre_clear: got %0d, want %0d", seq_len, exp_len);
    end
    ld_tile = 1'b1; randomEnable = 1'b1; seq_clear = 1'b1;
    @(posedge clock); #1;
    ld_tile = 1'b0; randomEnable = 1'b0; seq_clear = 1'b0;
    exp_q.delete();
    checks++;
    if (seq_len !== 5'd0) begin
      failures++;
      $display("FAIL seq_clear_vs_append: got %0d, want 0", seq_len);
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] t;
    load_tile(1'b0, 2'd0, t);
    writeEnable = 1'b1; counterEnable = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    checks++;
    if (plot !== 1'b1 || x !== 8'd75 || y !== 7'd53) begin
      failures++;
      $display("FAIL pre_reset_pix29: got plot=%b x=%0d y=%0d, want 1 75 53", plot, x, y);
    end
    #2;
    resetn = 1'b0; writeEnable = 1'b0; counterEnable = 1'b0;
    #1;
    checks++;
    if (plot !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: got plot=%b x=%0d y=%0d col=%b, want 0 0 0 0", plot, x, y, colour);
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    checks++;
    if (plot !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got plot=%b, want 0", plot);
    end
    load_tile(1'b0, 2'd1, t);
    write_one(8'd82, 7'd50, 3'b010, "restart_pixel0");
    load_tile(1'b1, 2'd0, t);
    write_one(ox(t), oy(t), base_c(t), "reseeded_random");
  endtask

  initial begin
    test_reset();
    test_boot_draw();
    test_flash_restore();
    test_seq_fill();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
